// File: rtl/arp_pkg.sv
// ARP protocol constants, receive FSM state encodings and byte-select helpers.
// Shared by the ARP receiver and the ARP transmitter.
package arp_pkg;

    // Ethernet / ARP field values
    localparam logic [15:0] ETH_TYPE_ARP  = 16'h0806;
    localparam logic [15:0] HW_TYPE       = 16'h0001;
    localparam logic [15:0] PROTOCOL_TYPE = 16'h0800;
    localparam logic [15:0] OPCODE_REQ    = 16'h0001;
    localparam logic [15:0] OPCODE_REPLY  = 16'h0002;
    localparam logic [7:0]  PREAMBLE_BYTE = 8'h55;
    localparam logic [7:0]  SFD_BYTE      = 8'hd5;
    localparam logic [47:0] BCAST_MAC     = 48'hff_ff_ff_ff_ff_ff;

    // Frame geometry, expressed as byte-counter values
    localparam logic [4:0] PREAMBLE_REPEAT = 5'd6;   // 0x55 bytes expected after the first one
    localparam logic [4:0] ETH_HEAD_LAST   = 5'd13;  // 14-byte Ethernet header
    localparam logic [4:0] ARP_DATA_LAST   = 5'd27;  // 28-byte ARP payload

    // Receive FSM states, one-hot
    typedef enum logic [4:0] {
        st_idle     = 5'b00001,
        st_preamble = 5'b00010,
        st_eth_head = 5'b00100,
        st_arp_data = 5'b01000,
        st_rx_end   = 5'b10000
    } arp_state_e;

    // Byte idx of a MAC address in wire order (0 = most significant byte)
    function automatic logic [7:0] mac_byte(input logic [47:0] mac, input logic [2:0] idx);
        case (idx)
            3'd0:    return mac[47:40];
            3'd1:    return mac[39:32];
            3'd2:    return mac[31:24];
            3'd3:    return mac[23:16];
            3'd4:    return mac[15:8];
            default: return mac[7:0];
        endcase
    endfunction

    // Byte idx of an IPv4 address in wire order (0 = most significant byte)
    function automatic logic [7:0] ip_byte(input logic [31:0] ip, input logic [1:0] idx);
        case (idx)
            2'd0:    return ip[31:24];
            2'd1:    return ip[23:16];
            2'd2:    return ip[15:8];
            default: return ip[7:0];
        endcase
    endfunction

endpackage

// File: rtl/arp_rx_if.sv
// GMII receive byte stream in, decoded ARP sender information out.
interface arp_rx_if;

    logic        gmii_rx_dv;
    logic [7:0]  gmii_rxd;
    logic        arp_rx_done;
    logic        arp_rx_type;
    logic [47:0] src_mac;
    logic [31:0] src_ip;

    // Source of the GMII stream / consumer of the decoded result
    modport master (
        output gmii_rx_dv, gmii_rxd,
        input  arp_rx_done, arp_rx_type, src_mac, src_ip
    );

    // The ARP receiver itself
    modport slave (
        input  gmii_rx_dv, gmii_rxd,
        output arp_rx_done, arp_rx_type, src_mac, src_ip
    );

endinterface

// File: rtl/arp_rx.sv
// ARP receiver: parses the GMII byte stream (preamble, Ethernet header, ARP
// payload), accepts request/reply packets addressed to BOARD_MAC and BOARD_IP,
// and publishes the sender MAC/IP and opcode with a one-cycle done pulse.
// Optional build macro ARP_RX_BCAST_EN: when defined, a destination MAC of
// ff:ff:ff:ff:ff:ff is accepted in addition to BOARD_MAC.
module arp_rx
    import arp_pkg::*;
#(
    parameter logic [47:0] BOARD_MAC = 48'h00_0a_35_01_fe_c0,
    parameter logic [31:0] BOARD_IP  = 32'hC0_A8_00_02
) (
    input  logic     clk,
    input  logic     rst_n,
    arp_rx_if.slave  rx
);

    arp_state_e  state;
    logic [4:0]  cnt;            // byte index within the current state
    logic [47:0] shadow_mac;     // sender MAC of the frame in flight
    logic [31:0] shadow_ip;      // sender IP of the frame in flight
    logic        shadow_type;    // 0 = request, 1 = reply
    logic        dst_board_ok;   // every destination byte so far matched BOARD_MAC
`ifdef ARP_RX_BCAST_EN
    logic        dst_bcast_ok;   // every destination byte so far was 0xff
`endif

    logic        board_byte_hit;
    logic        bcast_byte_hit;
    logic        ip_byte_hit;

    // Per-byte address comparisons against the current counter position
    always_comb begin
        // NOTE: every always_comb output gets a value on all paths so no latch is inferred.
        board_byte_hit = dst_board_ok && (rx.gmii_rxd == mac_byte(BOARD_MAC, cnt[2:0]));
`ifdef ARP_RX_BCAST_EN
        bcast_byte_hit = dst_bcast_ok && (rx.gmii_rxd == mac_byte(BCAST_MAC, cnt[2:0]));
`else
        bcast_byte_hit = 1'b0;
`endif
        ip_byte_hit    = (rx.gmii_rxd == ip_byte(BOARD_IP, cnt[1:0]));
    end

    // Receive FSM with byte counter, shadow capture and registered outputs
    // NOTE: sequential state uses non-blocking assignments only, so every register
    // sees the pre-edge value of every other register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // NOTE: the async reset clears everything, including the shadow
            // registers, so no stale sender data survives a mid-frame reset.
            state           <= st_idle;
            cnt             <= 5'd0;
            shadow_mac      <= 48'd0;
            shadow_ip       <= 32'd0;
            shadow_type     <= 1'b0;
            dst_board_ok    <= 1'b0;
`ifdef ARP_RX_BCAST_EN
            dst_bcast_ok    <= 1'b0;
`endif
            rx.arp_rx_done  <= 1'b0;
            rx.arp_rx_type  <= 1'b0;
            rx.src_mac      <= 48'd0;
            rx.src_ip       <= 32'd0;
        end else begin
            rx.arp_rx_done <= 1'b0;

            case (state)
                st_idle: begin
                    cnt <= 5'd0;
                    if (rx.gmii_rx_dv && rx.gmii_rxd == PREAMBLE_BYTE) begin
                        state <= st_preamble;
                    end
                end

                st_preamble: begin
                    if (!rx.gmii_rx_dv) begin
                        state <= st_idle;
                        cnt   <= 5'd0;
                    end else if (rx.gmii_rxd == PREAMBLE_BYTE && cnt < PREAMBLE_REPEAT) begin
                        cnt <= cnt + 5'd1;
                    end else if (rx.gmii_rxd == SFD_BYTE && cnt == PREAMBLE_REPEAT) begin
                        state        <= st_eth_head;
                        cnt          <= 5'd0;
                        dst_board_ok <= 1'b1;
`ifdef ARP_RX_BCAST_EN
                        dst_bcast_ok <= 1'b1;
`endif
                    end else begin
                        state <= st_rx_end;
                        cnt   <= 5'd0;
                    end
                end

                st_eth_head: begin
                    if (!rx.gmii_rx_dv) begin
                        state <= st_idle;
                        cnt   <= 5'd0;
                    end else if (cnt <= 5'd5) begin
                        // Destination MAC: must stay consistent with one accepted address
                        if (board_byte_hit || bcast_byte_hit) begin
                            dst_board_ok <= board_byte_hit;
`ifdef ARP_RX_BCAST_EN
                            dst_bcast_ok <= bcast_byte_hit;
`endif
                            cnt <= cnt + 5'd1;
                        end else begin
                            state <= st_rx_end;
                            cnt   <= 5'd0;
                        end
                    end else if (cnt == 5'd12) begin
                        if (rx.gmii_rxd == ETH_TYPE_ARP[15:8]) begin
                            cnt <= cnt + 5'd1;
                        end else begin
                            state <= st_rx_end;
                            cnt   <= 5'd0;
                        end
                    end else if (cnt == ETH_HEAD_LAST) begin
                        state <= (rx.gmii_rxd == ETH_TYPE_ARP[7:0]) ? st_arp_data : st_rx_end;
                        cnt   <= 5'd0;
                    end else begin
                        // Source MAC bytes are not needed
                        cnt <= cnt + 5'd1;
                    end
                end

                st_arp_data: begin
                    if (!rx.gmii_rx_dv) begin
                        state <= st_idle;
                        cnt   <= 5'd0;
                    end else if (cnt == 5'd7) begin
                        // Opcode low byte selects request or reply
                        if (rx.gmii_rxd == OPCODE_REQ[7:0]) begin
                            shadow_type <= 1'b0;
                            cnt         <= cnt + 5'd1;
                        end else if (rx.gmii_rxd == OPCODE_REPLY[7:0]) begin
                            shadow_type <= 1'b1;
                            cnt         <= cnt + 5'd1;
                        end else begin
                            state <= st_rx_end;
                            cnt   <= 5'd0;
                        end
                    end else if (cnt >= 5'd8 && cnt <= 5'd13) begin
                        shadow_mac <= {shadow_mac[39:0], rx.gmii_rxd};
                        cnt        <= cnt + 5'd1;
                    end else if (cnt >= 5'd14 && cnt <= 5'd17) begin
                        shadow_ip <= {shadow_ip[23:0], rx.gmii_rxd};
                        cnt       <= cnt + 5'd1;
                    end else if (cnt >= 5'd24) begin
                        // Target IP must be ours; the last byte commits the packet
                        if (!ip_byte_hit) begin
                            state <= st_rx_end;
                            cnt   <= 5'd0;
                        end else if (cnt == ARP_DATA_LAST) begin
                            rx.src_mac     <= shadow_mac;
                            rx.src_ip      <= shadow_ip;
                            rx.arp_rx_type <= shadow_type;
                            rx.arp_rx_done <= 1'b1;
                            state          <= st_rx_end;
                            cnt            <= 5'd0;
                        end else begin
                            cnt <= cnt + 5'd1;
                        end
                    end else begin
                        // Hardware/protocol type, lengths, opcode high byte, target MAC
                        cnt <= cnt + 5'd1;
                    end
                end

                st_rx_end: begin
                    // Swallow padding and FCS until the frame ends
                    cnt <= 5'd0;
                    if (!rx.gmii_rx_dv) begin
                        state <= st_idle;
                    end
                end

                default: begin
                    state <= st_idle;
                    cnt   <= 5'd0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arp_rx.sv
// Self-checking bench for arp_rx: a table of directed frames with hand-computed
// expected outputs, plus hand-written sequences for dv drop and mid-frame reset.
module tb_arp_rx;

    localparam logic [47:0] BOARD_MAC = 48'h00_0a_35_01_fe_c0;
    localparam logic [31:0] BOARD_IP  = 32'hC0_A8_00_02;

    logic clk;
    logic rst_n;

    arp_rx_if arp_if ();

    arp_rx #(
        .BOARD_MAC (BOARD_MAC),
        .BOARD_IP  (BOARD_IP)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .rx    (arp_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_bad = 0;
    int pulse_cnt = 0;
    int done_idx  = -1;
    int cur_idx   = -1;

    typedef struct packed {
        logic [47:0] dst;
        logic [15:0] etype;
        logic [15:0] op;
        logic [47:0] smac;
        logic [31:0] sip;
        logic [31:0] tip;
        logic [7:0]  npre;
        logic        exp_done;
        logic        exp_type;
        logic [47:0] exp_mac;
        logic [31:0] exp_ip;
    } vec_t;

    localparam int NVEC = 11;
    vec_t vecs [NVEC];

    // Count done pulses and note which byte was on the bus when one was seen
    always @(negedge clk) begin
        if (arp_if.arp_rx_done === 1'b1) begin
            pulse_cnt = pulse_cnt + 1;
            done_idx  = cur_idx;
        end
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec = n_vec + 1;
        if (act !== exp) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic check_outputs(input string tag, input logic t, input logic [47:0] m, input logic [31:0] ip);
        check({tag, "_type"}, {63'd0, arp_if.arp_rx_type}, {63'd0, t});
        check({tag, "_mac"},  {16'd0, arp_if.src_mac}, {16'd0, m});
        check({tag, "_ip"},   {32'd0, arp_if.src_ip}, {32'd0, ip});
    endtask

    function automatic vec_t mk(input logic [47:0] dst, input logic [15:0] etype, input logic [15:0] op,
                                input logic [47:0] smac, input logic [31:0] sip, input logic [31:0] tip,
                                input logic [7:0] npre, input logic exp_done, input logic exp_type,
                                input logic [47:0] exp_mac, input logic [31:0] exp_ip);
        vec_t v;
        v.dst = dst; v.etype = etype; v.op = op; v.smac = smac; v.sip = sip; v.tip = tip;
        v.npre = npre; v.exp_done = exp_done; v.exp_type = exp_type;
        v.exp_mac = exp_mac; v.exp_ip = exp_ip;
        return v;
    endfunction

    // Drive one frame; cut_at drops dv at that byte index, rst_at pulses rst_n there
    task automatic send_frame(input logic [47:0] dst, input logic [15:0] etype, input logic [15:0] op,
                              input logic [47:0] smac, input logic [31:0] sip, input logic [31:0] tip,
                              input int npre, input int cut_at, input int rst_at);
        logic [7:0]  f [$];
        logic [47:0] eth_src;
        logic [15:0] arp_fixed [3];
        eth_src      = 48'h02_00_00_00_00_99;
        arp_fixed[0] = 16'h0001;
        arp_fixed[1] = 16'h0800;
        arp_fixed[2] = 16'h0604;
        f = {};
        for (int i = 0; i < npre; i++) f.push_back(8'h55);
        f.push_back(8'hd5);
        for (int i = 0; i < 6; i++) f.push_back(dst[47-8*i -: 8]);
        for (int i = 0; i < 6; i++) f.push_back(eth_src[47-8*i -: 8]);
        f.push_back(etype[15:8]);
        f.push_back(etype[7:0]);
        for (int i = 0; i < 3; i++) begin
            f.push_back(arp_fixed[i][15:8]);
            f.push_back(arp_fixed[i][7:0]);
        end
        f.push_back(op[15:8]);
        f.push_back(op[7:0]);
        for (int i = 0; i < 6; i++) f.push_back(smac[47-8*i -: 8]);
        for (int i = 0; i < 4; i++) f.push_back(sip[31-8*i -: 8]);
        for (int i = 0; i < 6; i++) f.push_back(8'h00);
        for (int i = 0; i < 4; i++) f.push_back(tip[31-8*i -: 8]);
        for (int i = 0; i < 18; i++) f.push_back(8'h00);
        f.push_back(8'h12); f.push_back(8'h34); f.push_back(8'h56); f.push_back(8'h78);

        for (int i = 0; i <= f.size(); i++) begin
            @(posedge clk);
            #1;
            if (i == f.size() || i == cut_at) begin
                arp_if.gmii_rx_dv = 1'b0;
                arp_if.gmii_rxd   = 8'h00;
                break;
            end
            if (i == rst_at) begin
                rst_n = 1'b0;
                #1;
                check("rst_mid_done", {63'd0, arp_if.arp_rx_done}, 64'd0);
                check_outputs("rst_mid", 1'b0, 48'd0, 32'd0);
                #1;
                rst_n = 1'b1;
            end
            arp_if.gmii_rx_dv = 1'b1;
            arp_if.gmii_rxd   = f[i];
            cur_idx           = i;
        end
        cur_idx = -1;
        repeat (12) @(posedge clk);
        #2;
    endtask

    initial begin
        arp_if.gmii_rx_dv = 1'b0;
        arp_if.gmii_rxd   = 8'h00;
        rst_n             = 1'b0;

        // Directed vectors; expected outputs carry over when a frame is rejected
`ifdef ARP_RX_BCAST_EN
        vecs[0]  = mk(48'hff_ff_ff_ff_ff_ff, 16'h0806, 16'h0001, 48'h00_11_22_33_44_55, 32'hC0A80003, 32'hC0A80002, 8'd7,
                      1'b1, 1'b0, 48'h00_11_22_33_44_55, 32'hC0A80003);
        vecs[1]  = mk(BOARD_MAC, 16'h0806, 16'h0002, 48'h66_77_88_99_aa_bb, 32'hC0A80005, 32'hC0A80009, 8'd7,
                      1'b0, 1'b0, 48'h00_11_22_33_44_55, 32'hC0A80003);
`else
        vecs[0]  = mk(48'hff_ff_ff_ff_ff_ff, 16'h0806, 16'h0001, 48'h00_11_22_33_44_55, 32'hC0A80003, 32'hC0A80002, 8'd7,
                      1'b0, 1'b0, 48'd0, 32'd0);
        vecs[1]  = mk(BOARD_MAC, 16'h0806, 16'h0002, 48'h66_77_88_99_aa_bb, 32'hC0A80005, 32'hC0A80009, 8'd7,
                      1'b0, 1'b0, 48'd0, 32'd0);
`endif
        vecs[2]  = mk(BOARD_MAC, 16'h0806, 16'h0002, 48'h66_77_88_99_aa_bb, 32'hC0A80005, 32'hC0A80002, 8'd7,
                      1'b1, 1'b1, 48'h66_77_88_99_aa_bb, 32'hC0A80005);
        vecs[3]  = mk(BOARD_MAC, 16'h0800, 16'h0001, 48'h0a_0b_0c_0d_0e_0f, 32'hC0A80007, 32'hC0A80002, 8'd7,
                      1'b0, 1'b1, 48'h66_77_88_99_aa_bb, 32'hC0A80005);
        vecs[4]  = mk(BOARD_MAC, 16'h0806, 16'h0001, 48'h0a_0b_0c_0d_0e_0f, 32'hC0A80007, 32'hC0A80002, 8'd5,
                      1'b0, 1'b1, 48'h66_77_88_99_aa_bb, 32'hC0A80005);
        vecs[5]  = mk(BOARD_MAC, 16'h0806, 16'h0001, 48'h0a_0b_0c_0d_0e_0f, 32'hC0A80007, 32'hC0A80002, 8'd7,
                      1'b1, 1'b0, 48'h0a_0b_0c_0d_0e_0f, 32'hC0A80007);
        vecs[6]  = mk(BOARD_MAC, 16'h0806, 16'h0003, 48'h11_11_11_11_11_11, 32'hC0A80011, 32'hC0A80002, 8'd7,
                      1'b0, 1'b0, 48'h0a_0b_0c_0d_0e_0f, 32'hC0A80007);
        vecs[7]  = mk(48'h00_0a_35_01_fe_c1, 16'h0806, 16'h0002, 48'h11_11_11_11_11_11, 32'hC0A80011, 32'hC0A80002, 8'd7,
                      1'b0, 1'b0, 48'h0a_0b_0c_0d_0e_0f, 32'hC0A80007);
        vecs[8]  = mk(BOARD_MAC, 16'h0806, 16'h0002, 48'h11_11_11_11_11_11, 32'hC0A80011, 32'hC0A80002, 8'd8,
                      1'b0, 1'b0, 48'h0a_0b_0c_0d_0e_0f, 32'hC0A80007);
        vecs[9]  = mk(48'hff_ff_35_01_fe_c0, 16'h0806, 16'h0002, 48'h11_11_11_11_11_11, 32'hC0A80011, 32'hC0A80002, 8'd7,
                      1'b0, 1'b0, 48'h0a_0b_0c_0d_0e_0f, 32'hC0A80007);
        vecs[10] = mk(BOARD_MAC, 16'h0806, 16'h0002, 48'hde_ad_be_ef_00_01, 32'hC0A800FE, 32'hC0A80002, 8'd7,
                      1'b1, 1'b1, 48'hde_ad_be_ef_00_01, 32'hC0A800FE);

        // Reset state
        repeat (3) @(posedge clk);
        #2;
        check("reset_done", {63'd0, arp_if.arp_rx_done}, 64'd0);
        check_outputs("reset", 1'b0, 48'd0, 32'd0);
        #1;
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        // Table-driven frames
        for (int v = 0; v < NVEC; v++) begin
            pulse_cnt = 0;
            done_idx  = -1;
            send_frame(vecs[v].dst, vecs[v].etype, vecs[v].op, vecs[v].smac, vecs[v].sip, vecs[v].tip,
                       int'(vecs[v].npre), -1, -1);
            check($sformatf("v%0d_pulses", v), 64'(pulse_cnt), {63'd0, vecs[v].exp_done});
            check_outputs($sformatf("v%0d", v), vecs[v].exp_type, vecs[v].exp_mac, vecs[v].exp_ip);
            if (vecs[v].exp_done) begin
                // Done is seen one byte after ARP byte 27 was presented
                check($sformatf("v%0d_latency", v), 64'(done_idx), 64'(int'(vecs[v].npre) + 1 + 14 + 27 + 1));
            end
        end

        // dv dropped at ARP byte 20: frame discarded, next frame accepted
        pulse_cnt = 0;
        send_frame(BOARD_MAC, 16'h0806, 16'h0002, 48'h12_34_56_78_9a_bc, 32'hC0A80020, 32'hC0A80002, 7,
                   8 + 14 + 20, -1);
        check("drop_pulses", 64'(pulse_cnt), 64'd0);
        check_outputs("drop", 1'b1, 48'hde_ad_be_ef_00_01, 32'hC0A800FE);
        pulse_cnt = 0;
        send_frame(BOARD_MAC, 16'h0806, 16'h0001, 48'h02_aa_bb_cc_dd_ee, 32'hC0A80010, 32'hC0A80002, 7, -1, -1);
        check("after_drop_pulses", 64'(pulse_cnt), 64'd1);
        check_outputs("after_drop", 1'b0, 48'h02_aa_bb_cc_dd_ee, 32'hC0A80010);

        // Reset pulsed at Ethernet header byte 5: outputs clear at once, frame lost
        pulse_cnt = 0;
        send_frame(BOARD_MAC, 16'h0806, 16'h0002, 48'h00_11_22_33_44_55, 32'hC0A80003, 32'hC0A80002, 7,
                   -1, 8 + 5);
        check("rst_frame_pulses", 64'(pulse_cnt), 64'd0);
        check_outputs("rst_frame", 1'b0, 48'd0, 32'd0);
        pulse_cnt = 0;
        send_frame(BOARD_MAC, 16'h0806, 16'h0002, 48'h00_11_22_33_44_55, 32'hC0A80003, 32'hC0A80002, 7, -1, -1);
        check("after_rst_pulses", 64'(pulse_cnt), 64'd1);
        check_outputs("after_rst", 1'b1, 48'h00_11_22_33_44_55, 32'hC0A80003);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
